// File: rtl/z80_bus_frontend_if.sv
// z80_bus_frontend_if
//   Bundles the Z80 pin-side inputs and the clk-domain bus outputs of
//   z80_bus_frontend.
//   slave  : seen by the front end (pins/error_clear in, bus_* out)
//   master : seen by whatever drives the Z80 pins and consumes events
//   Z80 side : z80_write_strobe_b, z80_read_strobe_b (active-low, async),
//              z80_address_bus[7:0], z80_data_bus_in[7:0] (async)
//   Bus side : bus_address, bus_write_data, bus_write_pulse, bus_read_start,
//              bus_read_active, bus_read_end, error_count, error_clear
interface z80_bus_frontend_if;
  logic       z80_write_strobe_b;
  logic       z80_read_strobe_b;
  logic [7:0] z80_address_bus;
  logic [7:0] z80_data_bus_in;
  logic       error_clear;

  logic [7:0] bus_address;
  logic [7:0] bus_write_data;
  logic       bus_write_pulse;
  logic       bus_read_start;
  logic       bus_read_active;
  logic       bus_read_end;
  logic [7:0] error_count;

  modport slave (
    input  z80_write_strobe_b, z80_read_strobe_b, z80_address_bus,
           z80_data_bus_in, error_clear,
    output bus_address, bus_write_data, bus_write_pulse, bus_read_start,
           bus_read_active, bus_read_end, error_count
  );

  modport master (
    output z80_write_strobe_b, z80_read_strobe_b, z80_address_bus,
           z80_data_bus_in, error_clear,
    input  bus_address, bus_write_data, bus_write_pulse, bus_read_start,
           bus_read_active, bus_read_end, error_count
  );
endinterface

// File: rtl/z80_bus_frontend.sv
// z80_bus_frontend
//   Z80-side input stage for the Z80/Wishbone mailbox. Synchronises the
//   asynchronous Z80 strobes, address and data into clk, filters strobe
//   glitches shorter than FILTER_CYCLES, and turns qualified strobes into
//   single-cycle write / read-start / read-end events with captured address
//   and data. Protocol faults are counted in a saturating 8-bit counter.
//   Parameters : SYNC_STAGES (2..4), FILTER_CYCLES (1..15)
//   Ports      : clk      - the only clock
//                reset_b  - asynchronous, active-low reset
//                bus      - z80_bus_frontend_if.slave (pins in, events out)
module z80_bus_frontend #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset_b,
  z80_bus_frontend_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_QUAL,
    S_WR_ACTIVE,
    S_RD_QUAL,
    S_RD_ACTIVE,
    S_FAULT
  } state_t;

  localparam logic [3:0] LP_FILT = 4'(FILTER_CYCLES);

  // Synchronisers: address/data share the strobe depth so all stay aligned.
  logic [SYNC_STAGES-1:0]      r_ws_sync;
  logic [SYNC_STAGES-1:0]      r_rs_sync;
  logic [SYNC_STAGES-1:0][7:0] r_a_sync;
  logic [SYNC_STAGES-1:0][7:0] r_d_sync;

  logic       w_ws;
  logic       w_rs;
  logic [7:0] w_a;
  logic [7:0] w_d;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_qcnt;
  logic [3:0] w_qcnt_nxt;
  logic [3:0] w_qcnt_inc;

  logic w_err_evt;
  logic w_wr_pulse;
  logic w_rd_start;
  logic w_rd_end;
  logic w_cap_wr;
  logic w_cap_rd;

  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_wr_pulse;
  logic       r_rd_start;
  logic       r_rd_active;
  logic       r_rd_end;
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_ws_sync <= '1;
      r_rs_sync <= '1;
      r_a_sync  <= '0;
      r_d_sync  <= '0;
    end else begin
      r_ws_sync <= {r_ws_sync[SYNC_STAGES-2:0], bus.z80_write_strobe_b};
      r_rs_sync <= {r_rs_sync[SYNC_STAGES-2:0], bus.z80_read_strobe_b};
      r_a_sync  <= {r_a_sync[SYNC_STAGES-2:0], bus.z80_address_bus};
      r_d_sync  <= {r_d_sync[SYNC_STAGES-2:0], bus.z80_data_bus_in};
    end
  end

  assign w_ws = r_ws_sync[SYNC_STAGES-1];
  assign w_rs = r_rs_sync[SYNC_STAGES-1];
  assign w_a  = r_a_sync[SYNC_STAGES-1];
  assign w_d  = r_d_sync[SYNC_STAGES-1];

  assign w_qcnt_inc = r_qcnt + 4'd1;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= S_IDLE;
      r_qcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_qcnt  <= w_qcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_qcnt_nxt  = r_qcnt;
    w_err_evt   = 1'b0;
    w_wr_pulse  = 1'b0;
    w_rd_start  = 1'b0;
    w_rd_end    = 1'b0;
    w_cap_wr    = 1'b0;
    w_cap_rd    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_ws && !w_rs) begin
          w_state_nxt = S_FAULT;
          w_err_evt   = 1'b1;
        end else if (!w_ws) begin
          w_qcnt_nxt = 4'd1;
          if (LP_FILT == 4'd1) begin
            w_state_nxt = S_WR_ACTIVE;
            w_cap_wr    = 1'b1;
          end else begin
            w_state_nxt = S_WR_QUAL;
          end
        end else if (!w_rs) begin
          w_qcnt_nxt = 4'd1;
          if (LP_FILT == 4'd1) begin
            w_state_nxt = S_RD_ACTIVE;
            w_rd_start  = 1'b1;
            w_cap_rd    = 1'b1;
          end else begin
            w_state_nxt = S_RD_QUAL;
          end
        end
      end
      S_WR_QUAL: begin
        if (!w_rs) begin
          w_state_nxt = S_FAULT;
          w_err_evt   = 1'b1;
        end else if (w_ws) begin
          w_state_nxt = S_IDLE;
          w_err_evt   = 1'b1;
        end else begin
          w_qcnt_nxt = w_qcnt_inc;
          if (w_qcnt_inc == LP_FILT) begin
            w_state_nxt = S_WR_ACTIVE;
            // Capture on entry too: a minimum-width strobe releases on the
            // very next sample, so this may be the only low-strobe cycle.
            w_cap_wr    = 1'b1;
          end
        end
      end
      S_RD_QUAL: begin
        if (!w_ws) begin
          w_state_nxt = S_FAULT;
          w_err_evt   = 1'b1;
        end else if (w_rs) begin
          w_state_nxt = S_IDLE;
          w_err_evt   = 1'b1;
        end else begin
          w_qcnt_nxt = w_qcnt_inc;
          if (w_qcnt_inc == LP_FILT) begin
            w_state_nxt = S_RD_ACTIVE;
            w_rd_start  = 1'b1;
            w_cap_rd    = 1'b1;
          end
        end
      end
      S_WR_ACTIVE: begin
        if (w_ws) begin
          w_state_nxt = S_IDLE;
          w_wr_pulse  = 1'b1;
        end else if (!w_rs) begin
          w_state_nxt = S_FAULT;
          w_err_evt   = 1'b1;
        end else begin
          w_cap_wr = 1'b1;
        end
      end
      S_RD_ACTIVE: begin
        if (!w_ws) begin
          w_state_nxt = S_FAULT;
          w_err_evt   = 1'b1;
          w_rd_end    = 1'b1;
        end else if (w_rs) begin
          w_state_nxt = S_IDLE;
          w_rd_end    = 1'b1;
        end
      end
      S_FAULT: begin
        if (w_ws && w_rs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wr_pulse  <= 1'b0;
      r_rd_start  <= 1'b0;
      r_rd_active <= 1'b0;
      r_rd_end    <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_wr_pulse <= w_wr_pulse;
      r_rd_start <= w_rd_start;
      r_rd_end   <= w_rd_end;
      if (w_cap_wr) begin
        r_addr  <= w_a;
        r_wdata <= w_d;
      end else if (w_cap_rd) begin
        r_addr <= w_a;
      end
      if (w_rd_start)    r_rd_active <= 1'b1;
      else if (w_rd_end) r_rd_active <= 1'b0;
      if (bus.error_clear)                     r_err_cnt <= '0;
      else if (w_err_evt && r_err_cnt != '1)   r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.bus_address     = r_addr;
  assign bus.bus_write_data  = r_wdata;
  assign bus.bus_write_pulse = r_wr_pulse;
  assign bus.bus_read_start  = r_rd_start;
  assign bus.bus_read_active = r_rd_active;
  assign bus.bus_read_end    = r_rd_end;
  assign bus.error_count     = r_err_cnt;

endmodule
